imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot sequencer for the RV32I Processor.
- Holds the core in reset while it receives a program image as a byte stream, packs the bytes into little-endian 32-bit words, and writes them into byte-addressed instruction memory.
- Verifies a checksum, then releases the core.
- Sits between the external load port and the IM write port, and drives the Processor's reset input.

Parameters:
- IM_WORDS, 256, capacity of instruction memory in 32-bit words.
- ADDR_W, 10, width of the IM byte address; must equal log2(IM_WORDS*4).
- BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge.
- reload  in  1  single-cycle request to restart loading; honoured only in RUN or ERROR.
- im_we  out  1  IM word write strobe, one cycle per word.
- im_addr  out  ADDR_W  IM byte address of the word being written.
- im_wdata  out  32  word data; byte at address im_addr is im_wdata[7:0].
- core_rst_n  out  1  active-low reset to the Processor.
- done  out  1  image loaded and core released.
- err  out  1  load failed; sticky until reset or reload.
- err_code  out  2  0 = none, 1 = length overflow, 2 = checksum mismatch.
- words_loaded  out  ADDR_W-1  count of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous): state HDR, in_ready=0, im_we=0, im_addr=0, im_wdata=0, core_rst_n=0, done=0, err=0, err_code=0, words_loaded=0. Internal length, byte index and sum are cleared.
- in_ready is a registered output. It is 1 in HDR, PAYLOAD and CSUM, and 0 in RUN and ERROR. It goes high on the first edge after reset deasserts.
- Image format, all bytes in order:
  - 4-byte length N in words, LSB first.
  - N*4 payload bytes, each word LSB first.
  - 1 checksum byte equal to the sum mod 256 of the payload bytes only.
- HDR: accepts 4 bytes into len. On acceptance of the 4th byte:
  - N > IM_WORDS: go to ERROR with err_code=1.
  - N == 0: go to CSUM, expected sum 0.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - Each accepted byte is added to the 8-bit sum and placed into the lane given by byte_idx (0..3).
  - On acceptance of lane 3, the next cycle has im_we=1 for exactly one cycle, im_addr = BASE_ADDR + 4*words_loaded (pre-increment value), and im_wdata = the assembled word. words_loaded increments in that same cycle.
  - A new byte may be accepted in the write cycle. There is no backpressure caused by writes.
  - Gaps in in_valid simply stall the FSM. Partial word state is retained.
  - After the N-th word's 4th byte is accepted, go to CSUM.
- CSUM: accepts 1 byte.
  - Equal to sum: go to RUN.
  - Otherwise: go to ERROR with err_code=2.
- Ordering guarantee: the final im_we is never later than the cycle the checksum byte is accepted, so the IM contents are complete before core release.
- RUN:
  - core_rst_n=1 and done=1, both registered, high on the first edge after the checksum byte is accepted.
  - in_ready=0 and no IM writes occur.
- ERROR: err=1, core_rst_n stays 0, in_ready=0. Further bytes are ignored.
- reload=1 in RUN or ERROR: on the next edge go to HDR.
  - core_rst_n=0, done=0, err=0, err_code=0, words_loaded=0, sum=0, byte_idx=0.
  - in_ready rises on the following edge.
  - reload is ignored in HDR, PAYLOAD and CSUM.
- Reset mid-operation: immediately returns to the reset values. Partial words are discarded and previously written IM words are not cleared.
- Counter widths: words_loaded and len compare without wrap, since N ≤ IM_WORDS is checked before PAYLOAD. len is held at 32 bits for the overflow compare.

Test Plan:
- Normal load, stream 02 00 00 00 | 13 00 00 00 | 13 01 81 FF | A7 with in_valid continuous:
  - im_we pulses with (addr 0x000, data 0x00000013) and (addr 0x004, data 0xFF810113).
  - words_loaded=2, done=1, core_rst_n=1 one cycle after A7 is accepted, err=0.
- Same stream with the last byte 0xA6 -> ERROR, err=1, err_code=2, core_rst_n stays 0, in_ready=0. Then pulse reload -> err=0 and in_ready=1 two edges later; re-sending the correct stream reaches done=1.
- Header 01 01 00 00 (N=257 > 256) -> err_code=1 after the 4th header byte, no im_we ever asserted.
- Header 00 00 00 00 followed by checksum 00 -> done=1, zero IM writes. The same header followed by checksum 05 -> err_code=2.
- Normal load stream with in_valid toggling 1,0,0,1 per byte -> identical IM writes and final state to the first scenario; byte lanes are never corrupted across gaps.
- Assert reset=0 for 1 ns after 6 bytes of the first scenario's stream -> outputs immediately return to reset values. Re-sending the full stream gives the first-scenario result with the first write at addr 0x000.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot sequencer for the RV32I core. It keeps the core in reset while a
// program image arrives as a byte stream. The image is a 4-byte word count,
// then the payload, then a one-byte additive checksum. Payload bytes are
// packed into little-endian words and written to byte-addressed instruction
// memory. The core is released only when the checksum matches.
module imem_boot_loader #(
  parameter int IM_WORDS  = 256,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-2:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_PAYLOAD,
    S_CSUM,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [1:0]        ERR_NONE = 2'd0;
  localparam logic [1:0]        ERR_LEN  = 2'd1;
  localparam logic [1:0]        ERR_CSUM = 2'd2;
  localparam logic [31:0]       MAX_LEN  = 32'(IM_WORDS);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t              state;
  logic [31:0]         len;        // word count of the current image
  logic [23:0]         len_lo;     // header bytes 0..2 while the header is arriving
  logic [23:0]         word_lo;    // payload lanes 0..2 of the word being assembled
  logic [1:0]          byte_idx;   // lane of the next accepted byte
  logic [7:0]          sum;        // running payload checksum
  logic                accept;
  logic [31:0]         len_full;   // header value once its last byte is present
  logic [ADDR_W-2:0]   words_inc;  // word count after the current write
  logic [ADDR_W-1:0]   word_addr;  // byte address of the word being written

  // Handshake and helper values shared by the state machine.
  always_comb begin
    accept    = in_valid && in_ready;
    len_full  = {in_data, len_lo};
    words_inc = words_loaded + 1'b1;
    word_addr = BASE + {words_loaded[ADDR_W-3:0], 2'b00};
  end

  // Loader state machine; every output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_HDR;
      len          <= '0;
      len_lo       <= '0;
      word_lo      <= '0;
      byte_idx     <= '0;
      sum          <= '0;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
      core_rst_n   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
    end else begin
      // The write strobe is a single-cycle pulse.
      im_we <= 1'b0;

      case (state)
        S_HDR: begin
          // in_ready comes up on the first edge spent in HDR.
          in_ready <= 1'b1;
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: len_lo[7:0]   <= in_data;
              2'd1: len_lo[15:8]  <= in_data;
              2'd2: len_lo[23:16] <= in_data;
              default: begin
                len <= len_full;
                if (len_full > MAX_LEN) begin
                  state    <= S_ERROR;
                  in_ready <= 1'b0;
                  err      <= 1'b1;
                  err_code <= ERR_LEN;
                end else if (len_full == 32'd0) begin
                  state <= S_CSUM;
                end else begin
                  state <= S_PAYLOAD;
                end
              end
            endcase
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            sum      <= sum + in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= in_data;
              2'd1: word_lo[15:8]  <= in_data;
              2'd2: word_lo[23:16] <= in_data;
              default: begin
                // Lane 3 completes the word: write it on the next cycle
                // using the address of the pre-increment word count.
                im_we        <= 1'b1;
                im_addr      <= word_addr;
                im_wdata     <= {in_data, word_lo};
                words_loaded <= words_inc;
                if (32'(words_inc) == len) begin
                  state <= S_CSUM;
                end
              end
            endcase
          end
        end

        S_CSUM: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state      <= S_RUN;
              core_rst_n <= 1'b1;
              done       <= 1'b1;
            end else begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end

        S_RUN, S_ERROR: begin
          in_ready <= 1'b0;
          if (reload) begin
            // Restart from a clean header; in_ready returns one edge later.
            state        <= S_HDR;
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            sum          <= '0;
            byte_idx     <= '0;
            len          <= '0;
            len_lo       <= '0;
            word_lo      <= '0;
          end
        end

        default: begin
          state    <= S_HDR;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: normal load, bad checksum with reload,
// length overflow, empty image, gapped stream and a mid-load reset.
`timescale 1ns/100ps
module tb_imem_boot_loader;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       im_we;
  logic [9:0] im_addr;
  logic [31:0] im_wdata;
  logic       core_rst_n;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [8:0] words_loaded;

  int err_cnt   = 0;
  int check_cnt = 0;

  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  logic [7:0] good_stream [13] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                   8'h13, 8'h00, 8'h00, 8'h00,
                                   8'h13, 8'h01, 8'h81, 8'hFF, 8'hA7};

  imem_boot_loader #(.IM_WORDS(256), .ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_rst_n   (core_rst_n),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every IM write, sampled away from the active edge.
  always @(negedge clk) begin
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      $display("  write addr=0x%03h data=0x%08h", im_addr, im_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until a transfer edge; then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("  byte 0x%02h accepted", b);
    for (int i = 0; i < gap; i++) @(negedge clk);
  endtask

  task automatic send_good(input int gap, input logic [7:0] last);
    for (int i = 0; i < 12; i++) send_byte(good_stream[i], gap);
    send_byte(last, gap);
  endtask

  task automatic send4(input logic [31:0] hdr);
    for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], 0);
  endtask

  // Pulse reload, check the one-edge clear, then wait for in_ready.
  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "_err_clr"}, 32'(err), 32'd0);
    check({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_rdy_high"}, 32'(in_ready), 32'd1);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_good(input string tag);
    check({tag, "_nwr"},   32'(wr_addr.size()), 32'd2);
    check({tag, "_a0"},    32'(wr_addr[0]), 32'h000);
    check({tag, "_d0"},    wr_data[0], 32'h00000013);
    check({tag, "_a1"},    32'(wr_addr[1]), 32'h004);
    check({tag, "_d1"},    wr_data[1], 32'hFF810113);
    check({tag, "_wl"},    32'(words_loaded), 32'd2);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_crst"},  32'(core_rst_n), 32'd1);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_rdy"},   32'(in_ready), 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    #12;
    $display("reset state");
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_crst",  32'(core_rst_n), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_we",    32'(im_we), 32'd0);
    check("rst_wl",    32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("normal load");
    send_good(0, 8'hA7);
    check_good("norm");

    $display("bad checksum");
    do_reload("rl1");
    check("rl1_done", 32'(done), 32'd0);
    check("rl1_wl",   32'(words_loaded), 32'd0);
    send_good(0, 8'hA6);
    check("bad_err",  32'(err), 32'd1);
    check("bad_code", 32'(err_code), 32'd2);
    check("bad_crst", 32'(core_rst_n), 32'd0);
    check("bad_rdy",  32'(in_ready), 32'd0);
    check("bad_done", 32'(done), 32'd0);
    do_reload("rl2");
    check("rl2_code", 32'(err_code), 32'd0);
    send_good(0, 8'hA7);
    check_good("resend");

    $display("length overflow");
    do_reload("rl3");
    send4(32'h00000101);
    check("ovf_err",  32'(err), 32'd1);
    check("ovf_code", 32'(err_code), 32'd1);
    check("ovf_rdy",  32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_nwr",  32'(wr_addr.size()), 32'd0);

    $display("empty image");
    do_reload("rl4");
    send4(32'h0);
    send_byte(8'h00, 0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_crst", 32'(core_rst_n), 32'd1);
    check("empty_nwr",  32'(wr_addr.size()), 32'd0);
    check("empty_wl",   32'(words_loaded), 32'd0);
    do_reload("rl5");
    send4(32'h0);
    send_byte(8'h05, 0);
    check("empty_bad_code", 32'(err_code), 32'd2);
    check("empty_bad_done", 32'(done), 32'd0);

    $display("gapped stream");
    do_reload("rl6");
    send_good(2, 8'hA7);
    check_good("gap");

    $display("mid-load reset");
    do_reload("rl7");
    for (int i = 0; i < 6; i++) send_byte(good_stream[i], 0);
    #2 reset = 1'b0;
    #0.5;
    check("mid_rdy",  32'(in_ready), 32'd0);
    check("mid_crst", 32'(core_rst_n), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err",  32'(err), 32'd0);
    #0.5 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rdy_back", 32'(in_ready), 32'd1);
    wr_addr.delete();
    wr_data.delete();
    send_good(0, 8'hA7);
    check_good("after_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
